// File: rtl/dc_bu_line_window_mux_if.sv
// Line-window mux bus: buffer inputs, tap selects, stream controls and the
// valid/ready tap output. Optional stall_cnt under DC_BU_LWM_STALL_CNT_EN.
interface dc_bu_line_window_mux_if #(
  parameter int BITS_PER_PIXEL        = 24,
  parameter int BUFFER_NUM            = 5,
  parameter int TAP_NUM               = 4,
  parameter int PIXELS_PER_LINE_WIDTH = 12
);
  logic                                en;
  logic                                output_en;
  logic [PIXELS_PER_LINE_WIDTH-1:0]    pixels_per_line;
  logic                                next_line;
  logic [BUFFER_NUM*BITS_PER_PIXEL-1:0] buf_data;
  logic                                new_data;
  logic [TAP_NUM*BUFFER_NUM-1:0]       tap_sel;
  logic [TAP_NUM*BITS_PER_PIXEL-1:0]   taps_out;
  logic                                pixel_data_valid;
  logic                                pixel_data_ready;
  logic                                last_pixel;
  logic                                line_done;
  logic                                sel_error;
`ifdef DC_BU_LWM_STALL_CNT_EN
  logic [15:0]                         stall_cnt;
`endif

  modport master (
    output en, output_en, pixels_per_line, next_line, buf_data, new_data,
    output tap_sel, pixel_data_ready,
    input  taps_out, pixel_data_valid, last_pixel, line_done, sel_error
`ifdef DC_BU_LWM_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  en, output_en, pixels_per_line, next_line, buf_data, new_data,
    input  tap_sel, pixel_data_ready,
    output taps_out, pixel_data_valid, last_pixel, line_done, sel_error
`ifdef DC_BU_LWM_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/dc_bu_line_window_mux.sv
// Routes line-buffer pixels onto vertical-window taps and streams one line per
// request over a valid/ready register. Optional stall counter: DC_BU_LWM_STALL_CNT_EN.
module dc_bu_line_window_mux_tap #(
  parameter int BPP = 24,
  parameter int BN  = 5
) (
  input  logic [BN*BPP-1:0] buf_data,
  input  logic [BN-1:0]     sel,
  output logic [BPP-1:0]    pix,
  output logic              bad
);
  // descending scan so the lowest set bit wins
  always_comb begin
    pix = '0;
    for (int k = BN-1; k >= 0; k--)
      if (sel[k]) pix = buf_data[k*BPP +: BPP];
    bad = (sel == '0) || ((sel & (sel - BN'(1))) != '0);
  end
endmodule

module dc_bu_line_window_mux #(
  parameter int BITS_PER_PIXEL        = 24,
  parameter int BUFFER_NUM            = 5,
  parameter int TAP_NUM               = 4,
  parameter int PIXELS_PER_LINE_WIDTH = 12
) (
  input logic                   clk,
  input logic                   nrst,
  dc_bu_line_window_mux_if.slave bus
);
  localparam int BPP = BITS_PER_PIXEL;
  localparam int BN  = BUFFER_NUM;
  localparam int TN  = TAP_NUM;
  localparam int PW  = PIXELS_PER_LINE_WIDTH;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMED     = 2'd1;
  localparam logic [1:0] STREAM    = 2'd2;
  localparam logic [1:0] LINE_DONE = 2'd3;

  logic [1:0]        state;
  logic [PW-1:0]     cnt, ppl_r;
  logic              next_line_r;
  logic [TN*BPP-1:0] taps_q, mux;
  logic              valid_q, last_q, sel_err_q;
  logic [TN-1:0]     bad;
  logic              load, accept;

  generate
    for (genvar t = 0; t < TN; t++) begin : g_tap
      dc_bu_line_window_mux_tap #(.BPP(BPP), .BN(BN)) u_tap (
        .buf_data (bus.buf_data),
        .sel      (bus.tap_sel[t*BN +: BN]),
        .pix      (mux[t*BPP +: BPP]),
        .bad      (bad[t])
      );
    end
  endgenerate

  assign accept = valid_q && bus.pixel_data_ready;
  assign load   = (state == STREAM) && (!valid_q || bus.pixel_data_ready) && (cnt < ppl_r);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      cnt         <= '0;
      ppl_r       <= '0;
      next_line_r <= 1'b0;
      taps_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else if (bus.en) begin
      next_line_r <= bus.next_line;
      if (!bus.output_en) begin
        state     <= IDLE;
        cnt       <= '0;
        taps_q    <= '0;
        valid_q   <= 1'b0;
        last_q    <= 1'b0;
        sel_err_q <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: if (bus.new_data) begin
            ppl_r <= bus.pixels_per_line;
            cnt   <= '0;
            state <= (bus.pixels_per_line == '0) ? LINE_DONE : STREAM;
          end
          STREAM: begin
            if (next_line_r) begin
              // abort: a beat taken this cycle completes, otherwise it is dropped
              state   <= ARMED;
              cnt     <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else if (load) begin
              taps_q  <= mux;
              valid_q <= 1'b1;
              last_q  <= ((cnt + PW'(1)) == ppl_r);
              cnt     <= cnt + PW'(1);
              if (|bad) sel_err_q <= 1'b1;
            end else begin
              if (accept) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end
              if (cnt == ppl_r && (!valid_q || bus.pixel_data_ready)) state <= LINE_DONE;
            end
          end
          LINE_DONE: if (next_line_r) begin
            state <= ARMED;
            cnt   <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.taps_out         = taps_q;
  assign bus.pixel_data_valid = valid_q;
  assign bus.last_pixel       = last_q;
  assign bus.line_done        = (state == LINE_DONE);
  assign bus.sel_error        = sel_err_q;

`ifdef DC_BU_LWM_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      stall_q <= '0;
    else if (bus.en) begin
      if (!bus.output_en || next_line_r)
        stall_q <= '0;
      else if (valid_q && !bus.pixel_data_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_dc_bu_line_window_mux.sv
// Scoreboard bench: a beat-level line model predicts tap beats into a queue,
// a negedge monitor pops and compares every accepted beat.
module tb_dc_bu_line_window_mux;
  localparam int BPP = 24, BN = 5, TN = 4, PW = 12;
  localparam int P_IDLE = 0, P_ARMED = 1, P_STREAM = 2, P_DONE = 3;

  typedef struct packed { logic [TN*BPP-1:0] taps; logic last; } beat_t;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  dc_bu_line_window_mux_if #(.BITS_PER_PIXEL(BPP), .BUFFER_NUM(BN), .TAP_NUM(TN),
                             .PIXELS_PER_LINE_WIDTH(PW)) bus ();

  dc_bu_line_window_mux #(.BITS_PER_PIXEL(BPP), .BUFFER_NUM(BN), .TAP_NUM(TN),
                          .PIXELS_PER_LINE_WIDTH(PW)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  int tests = 0, fails = 0;
  beat_t exp_q[$];

  // line model state
  int phase = P_IDLE, rem = 0, stall = 0;
  bit occ = 0, nl_r = 0, sel_err = 0;
  bit buf_rand = 0, hold_chk = 1;
  logic [BN*BPP-1:0] cur_buf;
  logic [TN*BN-1:0]  cur_sel;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // tap t takes the lowest-numbered selected buffer; bad unless exactly one bit set
  function automatic void ref_mux(input logic [BN*BPP-1:0] b, input logic [TN*BN-1:0] s,
                                  output logic [TN*BPP-1:0] o, output bit bad);
    o = '0; bad = 0;
    for (int t = 0; t < TN; t++) begin
      int ones = 0, first = -1;
      for (int k = 0; k < BN; k++)
        if (s[t*BN + k]) begin
          ones++;
          if (first < 0) first = k;
        end
      if (first >= 0) o[t*BPP +: BPP] = b[first*BPP +: BPP];
      if (ones != 1) bad = 1;
    end
  endfunction

  function automatic logic [TN*BN-1:0] rand_sel();
    logic [TN*BN-1:0] s = '0;
    for (int t = 0; t < TN; t++)
      if ($urandom_range(0, 9) < 8) s[t*BN + $urandom_range(0, BN-1)] = 1'b1;
      else s[t*BN +: BN] = BN'($urandom);
    return s;
  endfunction

  // one clock: drive inputs, advance the model across the coming edge, check state after it
  task automatic step(input bit e, input bit oe, input bit rdy, input bit nd, input bit nl, input int ppl);
    logic [TN*BPP-1:0] m;
    bit bd;
    beat_t b;
    if (buf_rand)
      for (int k = 0; k < BN; k++) cur_buf[k*BPP +: BPP] = BPP'($urandom);
    bus.en = e; bus.output_en = oe; bus.pixel_data_ready = rdy; bus.new_data = nd;
    bus.next_line = nl; bus.pixels_per_line = PW'(ppl); bus.buf_data = cur_buf; bus.tap_sel = cur_sel;
    if (e) begin
      if (!oe) begin
        phase = P_IDLE; rem = 0; occ = 0; sel_err = 0; stall = 0;
        exp_q.delete();
      end else begin
        if (nl_r) stall = 0;
        else if (occ && !rdy && stall < 65535) stall++;
        case (phase)
          P_IDLE: phase = P_ARMED;
          P_ARMED: if (nd) begin
            if (ppl == 0) phase = P_DONE;
            else begin phase = P_STREAM; rem = ppl; end
          end
          P_STREAM: begin
            if (nl_r) begin
              if (occ && !rdy) exp_q.delete();
              occ = 0; rem = 0; phase = P_ARMED;
            end else if (rem > 0 && (!occ || rdy)) begin
              ref_mux(cur_buf, cur_sel, m, bd);
              b.taps = m; b.last = (rem == 1);
              exp_q.push_back(b);
              if (bd) sel_err = 1;
              rem--; occ = 1;
            end else begin
              if (occ && rdy) occ = 0;
              if (rem == 0 && !occ) phase = P_DONE;
            end
          end
          default: if (nl_r) phase = P_ARMED;
        endcase
      end
      nl_r = nl;
    end
    @(posedge clk); #1;
    chk("line_done", bus.line_done, phase == P_DONE);
    chk("valid", bus.pixel_data_valid, occ);
    chk("sel_error", bus.sel_error, sel_err);
`ifdef DC_BU_LWM_STALL_CNT_EN
    chk("stall_cnt", bus.stall_cnt, stall);
`endif
  endtask

  // rmode: 0 ready, 1 random, 2 five-cycle stall on beat 1; emode: 0 en, 1 random, 2 en low 3 cycles
  task automatic run_line(input int ppl, input int rmode, input int emode);
    int cyc = 0, stall_left = 5, cap = 20*ppl + 50;
    bit rdy, e;
    step(1, 1, 1, 1, 0, ppl);
    while (phase != P_DONE && cyc < cap) begin
      case (rmode)
        0: rdy = 1;
        1: rdy = $urandom_range(0, 1);
        default: if (occ && stall_left > 0) begin rdy = 0; stall_left--; end else rdy = 1;
      endcase
      case (emode)
        0: e = 1;
        1: e = ($urandom_range(0, 3) != 0);
        default: e = !(cyc >= 2 && cyc <= 4);
      endcase
      step(e, 1, rdy, 0, 0, ppl);
      cyc++;
    end
    chk("line_timeout", cyc < cap, 1);
    chk("line_done_end", bus.line_done, 1);
    chk("beats_pending", exp_q.size(), 0);
  endtask

  task automatic next_line_pulse();
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0);
  endtask

  task automatic flush();
    step(1, 0, 0, 0, 0, 0);
    chk("flush_taps", {bus.taps_out, bus.last_pixel}, 0);
    step(1, 1, 0, 0, 0, 0);
  endtask

  // monitor: every accepted beat must match the head of the queue; held beats stay still
  initial begin
    beat_t e;
    bit hold_prev = 0;
    logic [TN*BPP-1:0] prev_taps = '0;
    logic prev_last = 0;
    forever begin
      @(negedge clk);
      if (!nrst) hold_prev = 0;
      else begin
        if (hold_prev && hold_chk)
          chk("hold", {bus.pixel_data_valid, bus.last_pixel, bus.taps_out}, {1'b1, prev_last, prev_taps});
        hold_prev = bus.pixel_data_valid && !bus.pixel_data_ready && bus.output_en;
        prev_taps = bus.taps_out; prev_last = bus.last_pixel;
        if (bus.en && bus.output_en && bus.pixel_data_valid && bus.pixel_data_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL beat: got unexpected beat %0h expected none", bus.taps_out);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {bus.taps_out, bus.last_pixel}, e);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 0;
    bus.en = 0; bus.output_en = 0; bus.pixels_per_line = '0; bus.next_line = 0;
    bus.buf_data = '0; bus.new_data = 0; bus.tap_sel = '0; bus.pixel_data_ready = 0;
    for (int k = 0; k < BN; k++) cur_buf[k*BPP +: BPP] = BPP'(k + 1);
    cur_sel = {5'b01000, 5'b00100, 5'b00010, 5'b00001};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_taps", bus.taps_out, 0);
    chk("rst_valid", bus.pixel_data_valid, 0);
    chk("rst_last", bus.last_pixel, 0);
    chk("rst_line_done", bus.line_done, 0);
    chk("rst_sel_error", bus.sel_error, 0);
    nrst = 1;
    @(posedge clk); #1;
    step(1, 1, 0, 0, 0, 0);

    // identity selects, bk = k+1, full throughput
    run_line(4, 0, 0);
    next_line_pulse();

    // five-cycle stall on the first beat
    run_line(3, 2, 0);
`ifdef DC_BU_LWM_STALL_CNT_EN
    chk("stall_five", bus.stall_cnt, 5);
`endif
    next_line_pulse();

    // empty line
    run_line(0, 0, 0);
    next_line_pulse();
    chk("ppl0_armed", bus.line_done, 0);

    // multi-hot and all-zero selects
    cur_sel = {5'b00000, 5'b00110, 5'b00010, 5'b00001};
    run_line(2, 0, 0);
    chk("sel_err_set", bus.sel_error, 1);
    next_line_pulse();
    flush();
    chk("sel_err_clr", bus.sel_error, 0);

    // flush mid-line with a held beat, then restart
    cur_sel = {5'b10000, 5'b01000, 5'b00100, 5'b00010};
    buf_rand = 1;
    step(1, 1, 1, 1, 0, 8);
    step(1, 1, 1, 0, 0, 8);
    step(1, 1, 1, 0, 0, 8);
    step(1, 1, 0, 0, 0, 8);
    flush();
    run_line(8, 0, 0);
    next_line_pulse();

    // enable frozen mid-stream
    run_line(6, 1, 2);
    next_line_pulse();

    // abort via next_line mid-stream
    step(1, 1, 1, 1, 0, 10);
    for (int i = 0; i < 4; i++) step(1, 1, $urandom_range(0, 1), 0, 0, 10);
    hold_chk = 0;
    step(1, 1, $urandom_range(0, 1), 0, 1, 10);
    step(1, 1, $urandom_range(0, 1), 0, 0, 10);
    step(1, 1, 1, 0, 0, 10);
    hold_chk = 1;
    chk("abort_pending", exp_q.size(), 0);
    run_line(3, 1, 1);
    next_line_pulse();

    // maximum line length
    run_line(4095, 0, 0);
    next_line_pulse();

    // randomized lines
    for (int n = 0; n < 25; n++) begin
      cur_sel = rand_sel();
      run_line(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12), 1, 1);
      next_line_pulse();
      if ($urandom_range(0, 4) == 0) flush();
    end

    // asynchronous reset mid-line
    cur_sel = {5'b00001, 5'b00010, 5'b00100, 5'b01000};
    step(1, 1, 1, 1, 0, 6);
    step(1, 1, 0, 0, 0, 6);
    step(1, 1, 0, 0, 0, 6);
    #2 nrst = 0;
    #1 chk("async_rst", {bus.pixel_data_valid, bus.last_pixel, bus.line_done, bus.sel_error, bus.taps_out}, 0);
    exp_q.delete();
    phase = P_IDLE; rem = 0; occ = 0; nl_r = 0; sel_err = 0; stall = 0;
    @(negedge clk) nrst = 1;
    @(posedge clk); #1;
    step(1, 1, 0, 0, 0, 0);
    run_line(5, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dc_bu_line_window_mux.md
Name: dc_bu_line_window_mux

Overview:
- Parametrised successor to the buffering-unit line-ordering stage.
- Routes BUFFER_NUM line-buffer pixel streams onto TAP_NUM vertical-window taps using per-tap one-hot selects.
- Streams exactly pixels_per_line beats per line over a stall-safe valid/ready output register; data is held, never dropped, under backpressure.
- Sits between the line buffers and the vertical scaler filter; adds a line FSM, last-beat marking and select-error detection.

Parameters:
- BITS_PER_PIXEL, 24, width of one pixel.
- BUFFER_NUM, 5, number of line buffers (>=2).
- TAP_NUM, 4, number of output taps (>=1).
- PIXELS_PER_LINE_WIDTH, 12, width of the pixel count and beat counter.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- en  in  1  global clock enable; when low, all state is frozen.
- output_en  in  1  stream enable; low means synchronous flush.
- pixels_per_line  in  PIXELS_PER_LINE_WIDTH  beats per line; sampled on entry to STREAM.
- next_line  in  1  line-advance pulse.
- buf_data  in  BUFFER_NUM*BITS_PER_PIXEL  buffer pixels; buffer k occupies bits [k*BPP +: BPP].
- new_data  in  1  first valid buffer data of a line is present.
- tap_sel  in  TAP_NUM*BUFFER_NUM  one-hot buffer select; tap t occupies [t*BUFFER_NUM +: BUFFER_NUM].
- taps_out  out  TAP_NUM*BITS_PER_PIXEL  registered tap pixels.
- pixel_data_valid  out  1  output beat valid.
- pixel_data_ready  in  1  downstream ready.
- last_pixel  out  1  qualifies the current beat as the last beat of the line.
- line_done  out  1  high while in LINE_DONE.
- sel_error  out  1  sticky flag: an all-zero or multi-hot select was loaded.

Behaviour:
- Reset values: taps_out 0, pixel_data_valid 0, last_pixel 0, line_done 0, sel_error 0, FSM in IDLE, beat counter 0, next_line_r 0.
- Mux:
  - Tap t takes the buffer of the lowest set bit in its select.
  - An all-zero select gives 0 on that tap.
  - Any non-one-hot select captured in a load sets sel_error.
  - sel_error clears only on reset or on output_en low.
- Load condition: load = en && state==STREAM && (!pixel_data_valid || pixel_data_ready) && cnt<ppl_r.
  - On load: taps_out <= mux, pixel_data_valid <= 1, last_pixel <= (cnt==ppl_r-1), cnt <= cnt+1.
  - Latency is one clk from buf_data/tap_sel to taps_out.
- Hold: while pixel_data_valid && !pixel_data_ready, taps_out, last_pixel and valid stay stable.
- Drain: when a beat is accepted and no load occurs, pixel_data_valid <= 0 and last_pixel <= 0.
- next_line is registered once (next_line_r, updated when en is high) before it acts, so that the final handshake completes first.
- FSM:
  - IDLE -> ARMED when output_en is high.
  - ARMED -> STREAM on new_data; latch ppl_r <= pixels_per_line and set cnt <= 0.
  - ARMED -> LINE_DONE directly if pixels_per_line==0 at that moment; no beats are issued.
  - STREAM -> LINE_DONE once cnt==ppl_r and the final beat is accepted (valid falls).
  - LINE_DONE -> ARMED on next_line_r, with cnt <= 0.
  - next_line_r in STREAM aborts the line: go to ARMED, set cnt <= 0, and complete the pending beat only if it is accepted that cycle; otherwise drop it (valid <= 0).
- Flush: output_en low in any state, on an enabled cycle, forces IDLE, valid 0, taps_out 0, last_pixel 0, cnt 0, sel_error 0. Flush has priority over next_line_r and load.
- Counter: cnt saturates at ppl_r and never wraps. pixels_per_line = all-ones is legal.
- new_data in STREAM or LINE_DONE is ignored.

Optional Feature:
- Macro: DC_BU_LWM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments on each en cycle with pixel_data_valid && !pixel_data_ready; saturates at 16'hFFFF.
  - Clears on next_line_r, on flush and on reset.
- Undefined: no port and no logic.

Test Plan:
- ppl=4, tap_sel={t0:b0, t1:b1, t2:b2, t3:b3}, buf_data bk=k+1, ready=1, new_data pulse -> 4 consecutive beats with taps {1,2,3,4}; last_pixel only on beat 4; then line_done=1.
- ppl=3, ready low for 5 cycles after beat 1 -> beat 1 is held stable for 5 cycles, no beat is lost, exactly 3 accepted beats; with DC_BU_LWM_STALL_CNT_EN, stall_cnt=5.
- ppl=0, new_data -> no valid asserted; line_done=1 the next cycle; next_line returns the FSM to ARMED.
- tap_sel t2=5'b00110 and t3=5'b00000 -> tap2 carries b1, tap3 is 0, sel_error=1 until output_en drops.
- output_en low mid-line at beat 2 of 8 with ready=0 -> next enabled cycle valid=0, taps_out=0, IDLE; re-enable plus new_data restarts at beat 1.
- en low for 3 cycles mid-stream -> outputs and counter frozen; the stream resumes without duplicating or skipping beats; async nrst mid-line returns all outputs to 0 immediately.
